// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants for the arithmetic blocks: multiplier FSM encodings and sizing helpers.
// Pure declarations; no latency or flow control of its own.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_DEFAULT_N = 8;

  // Bits needed for a step counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder built from full-adder cells.
// Purely combinational: zero cycles of latency and no flow control.
module ripple_carry_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned N x N sequential shift-add multiplier; done pulses one cycle after N RUN steps.
// Latency N+1 cycles, issue interval N+2; start is accepted only while ready is high.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int N = MUL_DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_width(N);

  mul_state_t    state;
  logic [N-1:0]  mcand;
  logic [N-1:0]  p_hi;
  logic [N-1:0]  p_lo;
  logic [CW-1:0] cnt;

  logic [N-1:0]  add_b;
  logic [N-1:0]  sum;
  logic          cout;

  // Partial product only accumulates the multiplicand when the current multiplier LSB is set.
  assign add_b = p_lo[0] ? mcand : '0;

  ripple_carry_adder #(.N(N)) u_adder (
    .a    (p_hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            p_lo  <= b;
            p_hi  <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Adder carry-out becomes the new top bit; multiplier bits shift out of p_lo.
          {p_hi, p_lo} <= {cout, sum, p_lo[N-1:1]};
          cnt          <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready   = (state == IDLE);
  assign done    = (state == DONE);
  assign product = {p_hi, p_lo};

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, N bits: unsigned multiplicand; sampled with start.
REQ-006 The block SHALL have port b, input, N bits: unsigned multiplier; sampled with start.
REQ-007 The block SHALL have port ready, output, 1 bit: high exactly when the FSM is in IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking product valid.
REQ-009 The block SHALL have port product, output, 2N bits: unsigned a*b result.

Function
REQ-010 The FSM SHALL have three states, IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE when the step count reaches N; DONE->IDLE unconditionally after one cycle.
REQ-011 Internal registers SHALL be mcand[N-1:0], p_hi[N-1:0], p_lo[N-1:0] and cnt, where cnt is wide enough to hold N.
REQ-012 On start in IDLE, the block SHALL set mcand<=a, p_lo<=b, p_hi<=0 and cnt<=0, and SHALL enter RUN.
REQ-013 Each RUN cycle SHALL drive the adder with operand a=p_hi, operand b=(p_lo[0] ? mcand : 0) and cin=0.
REQ-014 Each RUN cycle SHALL then update {p_hi,p_lo} <= {cout, sum, p_lo[N-1:1]} and cnt<=cnt+1.
REQ-015 After exactly N RUN cycles, the FSM SHALL go to DONE.
REQ-016 product SHALL be driven as {p_hi,p_lo}.
REQ-017 product SHALL be valid when done is high and SHALL hold that value through IDLE until the next start is accepted.
REQ-018 Latency SHALL be fixed: with start sampled at edge 0, RUN occupies edges 1..N and done is high in the cycle after edge N.
REQ-019 Accepting a new start SHALL require one IDLE cycle after DONE, so the minimum issue interval is N+2 cycles.
REQ-020 start SHALL be ignored in RUN and DONE, with no effect on state, operands or outputs.
REQ-021 Changes on a and b outside the start cycle SHALL have no effect.
REQ-022 Zero operands SHALL need no special case: the block still takes N steps and yields product 0.
REQ-023 Arithmetic SHALL be unsigned only, and the adder carry-out SHALL be the only carry path into p_hi; no overflow is possible within 2N bits.

Reset
REQ-024 When rst_n=0 at a rising edge, the state SHALL go to IDLE and mcand, p_hi, p_lo and cnt SHALL go to 0.
REQ-025 Output values during and after reset SHALL be ready=1, done=0 and product=0.
REQ-026 A reset asserted mid-operation (RUN or DONE) SHALL abort the multiply with no done pulse, and no partial product SHALL be retained.
REQ-027 If start is high in the same cycle as rst_n=0, reset SHALL take priority and start SHALL be ignored.

Structure
REQ-028 The three state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL be defined in a shared package/include with the team's other arithmetic-block constants.
REQ-029 The block SHALL instantiate exactly one sub-module, ripple_carry_adder #(N), with ports a, b, cin, sum and cout; no behavioural "+" operator on the datapath.
REQ-030 Everything other than the adder SHALL be a single clocked process plus combinational output assigns.

Verification
REQ-031 With N=8, a=15, b=1 and start for 1 cycle: ready drops at the next edge, done pulses exactly 9 cycles after the start edge, and product=16'd15.
REQ-032 a=255, b=255: product=16'hFE01; in the RUN steps, adder cout=1 must propagate into p_hi.
REQ-033 a=0, b=200, then a=200, b=0: product=0 both times, with identical latency.
REQ-034 Start a=12, b=10; at RUN step 3 assert start again with a=3, b=3: product=120, and exactly one done pulse is produced.
REQ-035 Start a=170, b=85; drop rst_n at RUN step 4 for 1 cycle: no done pulse, ready=1, product=0; then a new multiply of 7*9 gives 63.
REQ-036 Back-to-back runs issuing start as soon as ready=1: the interval between done pulses is N+2 cycles, and each product matches a reference a*b over 100 random pairs.
